// File: rtl/board_io_pkg.sv
// Shared board I/O definitions: debounce FSM states and the processor switch bus width.
package board_io_pkg;

   // Width of the processor's switch_in_data port; switch values are zero-extended to this.
   localparam int unsigned SWITCH_BUS_W = 16;

   // Debounce FSM: holding a committed value, or qualifying a new candidate.
   typedef enum logic {
      ST_STABLE = 1'b0,
      ST_SETTLE = 1'b1
   } debounce_state_t;

endpackage : board_io_pkg

// File: rtl/sync_ff.sv
// Parameterized-depth, parameterized-width flop chain with synchronous active-high reset.
// Used as a multi-stage synchronizer for asynchronous board inputs.
module sync_ff #(
   parameter int unsigned STAGES = 2,
   parameter int unsigned WIDTH  = 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_chain [STAGES];

   // Shift the raw input through the chain; reset clears every stage.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < int'(STAGES); i++) begin
            r_chain[i] <= '0;
         end
      end else begin
         r_chain[0] <= i_d;
         for (int i = 1; i < int'(STAGES); i++) begin
            r_chain[i] <= r_chain[i-1];
         end
      end
   end

   assign o_q = r_chain[STAGES-1];

endmodule : sync_ff

// File: rtl/switch_input_debounce.sv
// Slide-switch input conditioning: synchronizes the raw switch bank, debounces the
// whole bank with a single shared settle counter and presents a zero-extended,
// glitch-free value with a sticky change flag and a committed-change counter.
module switch_input_debounce
   import board_io_pkg::*;
#(
   parameter int unsigned WIDTH           = 14,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [WIDTH-1:0]        switches,
   input  logic                    rd_ack,
   output logic [SWITCH_BUS_W-1:0] switch_data,
   output logic                    data_changed,
   output logic [7:0]              event_count
);

   localparam int unsigned        CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] w_synced;

   debounce_state_t  r_state;
   logic [WIDTH-1:0] r_candidate;
   logic [WIDTH-1:0] r_stable;
   logic [CNT_W-1:0] r_cnt;
   logic             r_changed;
   logic [7:0]       r_event_count;

   sync_ff #(
      .STAGES (SYNC_STAGES),
      .WIDTH  (WIDTH)
   ) u_sync (
      .i_clk (clk),
      .i_rst (rst),
      .i_d   (switches),
      .o_q   (w_synced)
   );

   // Debounce FSM with registered outputs. Any change of the synchronized bank
   // during settling restarts the window for all bits; a commit that lands on the
   // already-stable value (bounce back) is silent.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_STABLE;
         r_candidate   <= '0;
         r_stable      <= '0;
         r_cnt         <= '0;
         r_changed     <= 1'b0;
         r_event_count <= 8'd0;
      end else begin
         // Acknowledge clears first so a same-cycle changing commit below wins.
         if (rd_ack) begin
            r_changed <= 1'b0;
         end

         unique case (r_state)
            ST_STABLE: begin
               if (w_synced != r_stable) begin
                  r_candidate <= w_synced;
                  r_cnt       <= '0;
                  r_state     <= ST_SETTLE;
               end
            end

            ST_SETTLE: begin
               if (w_synced != r_candidate) begin
                  r_candidate <= w_synced;
                  r_cnt       <= '0;
               end else if (r_cnt == CNT_LAST) begin
                  r_stable <= r_candidate;
                  r_state  <= ST_STABLE;
                  if (r_candidate != r_stable) begin
                     r_changed     <= 1'b1;
                     r_event_count <= r_event_count + 8'd1;
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end

            default: begin
               r_state <= ST_STABLE;
            end
         endcase
      end
   end

   assign switch_data  = SWITCH_BUS_W'(r_stable);
   assign data_changed = r_changed;
   assign event_count  = r_event_count;

endmodule : switch_input_debounce

// File: tb/tb_switch_input_debounce.sv
// Self-checking bench for switch_input_debounce (WIDTH=14, SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
module tb_switch_input_debounce;
   import board_io_pkg::*;

   localparam int unsigned W    = 14;
   localparam int unsigned SYNC = 2;
   localparam int unsigned DEB  = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [W-1:0]  switches;
   logic          rd_ack;
   logic [15:0]   switch_data;
   logic          data_changed;
   logic [7:0]    event_count;

   int n_tests = 0;
   int n_fail  = 0;

   switch_input_debounce #(
      .WIDTH           (W),
      .SYNC_STAGES     (SYNC),
      .DEBOUNCE_CYCLES (DEB)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .switches     (switches),
      .rd_ack       (rd_ack),
      .switch_data  (switch_data),
      .data_changed (data_changed),
      .event_count  (event_count)
   );

   always #5 clk = ~clk;

   // Reference model: the FSM sees the switch level from SYNC edges earlier; the
   // committed value becomes the seen value once it has been identical over the
   // last DEB+1 edges.
   logic [W-1:0] m_sync_q [$];
   logic [W-1:0] m_hist   [$];
   logic [W-1:0] m_stable;
   logic         m_changed;
   int           m_count;

   task automatic model_step(input logic r, input logic [W-1:0] s, input logic a);
      logic [W-1:0] sv;
      logic [W-1:0] nxt;
      bit           same;
      if (r) begin
         m_sync_q.delete();
         m_hist.delete();
         for (int i = 0; i < int'(SYNC); i++) m_sync_q.push_back('0);
         for (int i = 0; i < int'(DEB) + 1; i++) m_hist.push_back('0);
         m_stable  = '0;
         m_changed = 1'b0;
         m_count   = 0;
      end else begin
         sv = m_sync_q.pop_front();
         m_sync_q.push_back(s);
         m_hist.push_back(sv);
         void'(m_hist.pop_front());
         same = 1'b1;
         foreach (m_hist[k]) if (m_hist[k] != sv) same = 1'b0;
         nxt = same ? sv : m_stable;
         if (nxt != m_stable) begin
            m_changed = 1'b1;
            m_count   = (m_count + 1) % 256;
         end else if (a) begin
            m_changed = 1'b0;
         end
         m_stable = nxt;
      end
   endtask

   // Apply inputs across one rising edge, then sample on the following falling edge.
   task automatic cycle(input logic r, input logic [W-1:0] s, input logic a);
      rst      = r;
      switches = s;
      rd_ack   = a;
      @(posedge clk);
      model_step(r, s, a);
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic chk_model(input string tag);
      chk({tag, "_data"},    32'(switch_data),  32'({2'b00, m_stable}));
      chk({tag, "_changed"}, 32'(data_changed), 32'(m_changed));
      chk({tag, "_count"},   32'(event_count),  32'(m_count));
   endtask

   typedef struct {
      logic         rst;
      logic [W-1:0] sw;
      logic         ack;
      logic [15:0]  d;
      logic         c;
      logic [7:0]   n;
   } vec_t;

   vec_t tbl [$];

   task automatic add(input int reps, input logic r, input logic [W-1:0] s, input logic a,
                      input logic [15:0] d, input logic c, input logic [7:0] n);
      vec_t v;
      v.rst = r; v.sw = s; v.ack = a; v.d = d; v.c = c; v.n = n;
      for (int i = 0; i < reps; i++) tbl.push_back(v);
   endtask

   initial begin
      logic [W-1:0] prev;
      logic [W-1:0] v;
      int           first_idx;
      int           cnt0;
      int           hold;
      logic         a;

      rst = 1'b1; switches = '0; rd_ack = 1'b0;

      // Reset with all switches high, then 3FFF -> 0 -> 0025 with acknowledges.
      add(2, 1'b1, 14'h3FFF, 1'b0, 16'h0000, 1'b0, 8'd0);
      add(6, 1'b0, 14'h3FFF, 1'b0, 16'h0000, 1'b0, 8'd0);
      add(1, 1'b0, 14'h3FFF, 1'b0, 16'h3FFF, 1'b1, 8'd1);
      add(1, 1'b0, 14'h3FFF, 1'b1, 16'h3FFF, 1'b0, 8'd1);
      add(6, 1'b0, 14'h0000, 1'b0, 16'h3FFF, 1'b0, 8'd1);
      add(1, 1'b0, 14'h0000, 1'b0, 16'h0000, 1'b1, 8'd2);
      add(1, 1'b0, 14'h0000, 1'b1, 16'h0000, 1'b0, 8'd2);
      add(6, 1'b0, 14'h0025, 1'b0, 16'h0000, 1'b0, 8'd2);
      add(1, 1'b0, 14'h0025, 1'b0, 16'h0025, 1'b1, 8'd3);
      add(1, 1'b0, 14'h0025, 1'b1, 16'h0025, 1'b0, 8'd3);

      foreach (tbl[i]) begin
         cycle(tbl[i].rst, tbl[i].sw, tbl[i].ack);
         chk($sformatf("tbl%0d_data", i),    32'(switch_data),  32'(tbl[i].d));
         chk($sformatf("tbl%0d_changed", i), 32'(data_changed), 32'(tbl[i].c));
         chk($sformatf("tbl%0d_count", i),   32'(event_count),  32'(tbl[i].n));
      end

      // Bounce: 0001/0000 alternating every 2 cycles, then held at 0001.
      cycle(1'b1, '0, 1'b0); cycle(1'b1, '0, 1'b0);
      cycle(1'b0, '0, 1'b0); cycle(1'b0, '0, 1'b0);
      cnt0      = m_count;
      first_idx = -1;
      for (int i = 0; i < 20; i++) begin
         v = (i < 10 && ((i / 2) % 2) == 1) ? 14'h0000 : 14'h0001;
         cycle(1'b0, v, 1'b0);
         chk_model("bounce");
         if (first_idx < 0 && switch_data == 16'h0001) first_idx = i;
      end
      chk("bounce_latency", 32'(first_idx), 32'd14);
      chk("bounce_count", 32'(event_count), 32'((cnt0 + 1) % 256));

      // Return to 0 and acknowledge, then a 3-cycle glitch that must not commit.
      for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b0);
      cycle(1'b0, '0, 1'b1);
      chk_model("pre_glitch");
      cnt0 = m_count;
      for (int i = 0; i < 13; i++) begin
         cycle(1'b0, (i < 3) ? 14'h0004 : 14'h0000, 1'b0);
         chk("glitch_data", 32'(switch_data), 32'h0);
         chk("glitch_changed", 32'(data_changed), 32'h0);
         chk("glitch_count", 32'(event_count), 32'(cnt0));
      end
      chk("glitch_state", 32'(dut.r_state), 32'(ST_STABLE));

      // Acknowledge on the same edge as a changing commit: set wins.
      for (int i = 0; i < 6; i++) cycle(1'b0, 14'h0100, 1'b0);
      cycle(1'b0, 14'h0100, 1'b1);
      chk("ackcommit_data", 32'(switch_data), 32'h0100);
      chk("ackcommit_changed", 32'(data_changed), 32'h1);
      cycle(1'b0, 14'h0100, 1'b1);
      chk("ack_clear", 32'(data_changed), 32'h0);
      chk_model("ack");

      // 256 committed changes wrap the event counter back to 0.
      cycle(1'b1, '0, 1'b0); cycle(1'b1, '0, 1'b0);
      cycle(1'b0, '0, 1'b0);
      prev = '0;
      for (int i = 0; i < 256; i++) begin
         v = W'($urandom_range(1, 14'h3FFF));
         if (v == prev) v = v ^ 14'h0001;
         for (int k = 0; k < 7; k++) begin
            cycle(1'b0, v, 1'b0);
            chk_model("wrap");
         end
         chk("wrap_data", 32'(switch_data), 32'({2'b00, v}));
         chk("wrap_count", 32'(event_count), 32'((i + 1) % 256));
         prev = v;
      end
      chk("wrap_zero", 32'(event_count), 32'h0);

      // Randomized stimulus against the reference model.
      for (int i = 0; i < 400; i++) begin
         v    = ($urandom_range(0, 3) == 0) ? W'($urandom) : (prev ^ W'(1 << $urandom_range(0, W - 1)));
         hold = $urandom_range(1, 9);
         for (int k = 0; k < hold; k++) begin
            a = ($urandom_range(0, 7) == 0);
            cycle(($urandom_range(0, 399) == 0), v, a);
            chk_model("rand");
         end
         prev = v;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_switch_input_debounce

// File: doc/switch_input_debounce.md
# switch_input_debounce

Board-input conditioning block feeding the RV32IM core's 16-bit `switch_in_data` port. It synchronizes the raw slide-switch bank into `clk`, debounces the whole bank with one shared settle counter, and presents a glitch-free, zero-extended 16-bit value. A sticky change flag with a read-acknowledge handshake lets software detect new input without busy-compare loops. It is the input-side counterpart of the display path: switches go into the processor here, and display data comes out of it.

## Interface
- `WIDTH`, 14: number of physical switches; legal range 1..16.
- `SYNC_STAGES`, 2: synchronizer depth per bit; minimum 2.
- `DEBOUNCE_CYCLES`, 1_000_000: stable cycles required before commit (10 ms at 100 MHz); minimum 2.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `switches` in WIDTH: raw asynchronous switch levels.
- `rd_ack` in 1: one-cycle pulse; software has consumed `switch_data`.
- `switch_data` out 16: `{(16-WIDTH) zeros, stable}`.
- `data_changed` out 1: sticky; set on a committed value change.
- `event_count` out 8: count of committed changes, modulo 256.

## Operation
- Synchronizer: each bit passes through `SYNC_STAGES` flops. The output is `synced`.
- FSM states are `ST_STABLE` and `ST_SETTLE`. The block keeps `candidate[WIDTH]`, `stable[WIDTH]` and `cnt[$clog2(DEBOUNCE_CYCLES)]`.
- `ST_STABLE`:
  - If `synced != stable`: set `candidate <= synced`, `cnt <= 0`, go to `ST_SETTLE`.
  - Otherwise hold.
- `ST_SETTLE`:
  - If `synced != candidate`: set `candidate <= synced`, `cnt <= 0`, stay in `ST_SETTLE`. Any bit bouncing restarts the whole bank.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: commit with `stable <= candidate` and go to `ST_STABLE`.
  - Else `cnt <= cnt+1`.
- Commit where `candidate == stable` (input bounced back to its old value): the FSM returns to `ST_STABLE`. No flag is set and no count is taken.
- Commit where `candidate != stable`:
  - `data_changed <= 1`.
  - `event_count <= event_count+1`, wrapping 255→0.
- `rd_ack` clears `data_changed` on the next edge. If a changing commit and `rd_ack` fall on the same cycle, set wins and the flag stays 1.
- `rd_ack` has no effect on `stable`, the FSM or `event_count`.
- Reset values:
  - All synchronizer flops, `candidate`, `stable` and `cnt` = 0; state = `ST_STABLE`.
  - Outputs: `switch_data = 16'h0000`, `data_changed = 0`, `event_count = 0`.
  - Reset mid-settle abandons the candidate. Switches held non-zero through reset are re-qualified after reset and produce one change event.

## Timing
- All outputs are registered. There is no combinational path from `switches` or `rd_ack` to any output.
- Latency from `switches` changing (stable thereafter) to `switch_data` updating: exactly `SYNC_STAGES + DEBOUNCE_CYCLES + 1` clock edges. With 2/4 that is 7 edges.
- `data_changed` and `event_count` update on the same edge as `switch_data`.
- `rd_ack` to `data_changed` low: 1 edge.
- Any `synced` disturbance during `ST_SETTLE` extends the latency by the full `DEBOUNCE_CYCLES` window, measured from the last disturbance.

## Structure
- Shared package `board_io_pkg` holds:
  - the FSM state enum (`ST_STABLE`, `ST_SETTLE`);
  - the constant `SWITCH_BUS_W = 16`, also used by the processor's `switch_in_data` width.
- One sub-module, `sync_ff`: a parameterized-depth, parameterized-width flop chain with synchronous reset. It is instantiated once with width `WIDTH`.

## Test plan
All scenarios use `WIDTH=14`, `SYNC_STAGES=2`, `DEBOUNCE_CYCLES=4`.
- Reset with `switches=14'h3FFF` held:
  - Outputs are 0 during reset.
  - 7 edges after reset release: `switch_data=16'h3FFF`, `data_changed=1`, `event_count=1`.
- `switches` 0→`14'h0025` held:
  - `switch_data` is 16'h0000 through edge 6 and 16'h0025 at edge 7.
  - Upper two bits stay 0.
- Bounce 0→`0x0001`→0→`0x0001`, alternating every 2 cycles for 10 cycles, then held:
  - No intermediate commit.
  - `switch_data=16'h0001` exactly 7 edges after the last transition.
  - `event_count` increments by 1.
- Glitch 0→`0x0004` for 3 cycles then back to 0:
  - `switch_data` stays 0, `data_changed` stays 0, `event_count` unchanged.
  - FSM returns to `ST_STABLE`.
- `rd_ack` pulse asserted on the same edge as a changing commit: `data_changed` remains 1. A later lone `rd_ack` clears it in 1 edge.
- 256 distinct committed changes: `event_count` wraps to 0, and `switch_data` tracks each change.
